// File: rtl/adder_n_bit.sv
// adder_n_bit: N-bit unsigned adder with a registered N+1-bit sum and a
// one-cycle out_valid pulse. Defining ADDER_BCD_OUT_EN adds a packed-BCD
// copy of the sum, registered in the same stage as sum.
module adder_n_bit #(
  parameter int unsigned N      = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              out_valid,
`ifdef ADDER_BCD_OUT_EN
  output logic [4*DIGITS-1:0] bcd,
`endif
  output logic [N:0]        sum
);

  localparam int unsigned SW = N + 1;
  localparam int unsigned BW = 4 * DIGITS;

  logic [SW-1:0] sum_d;
  logic [SW-1:0] sum_q;
  logic          valid_q;

  // Full-width addition; the extra bit holds the carry so nothing truncates.
  always_comb begin
    sum_d = SW'(a) + SW'(b);
  end

`ifdef ADDER_BCD_OUT_EN
  logic [BW-1:0] bcd_d;
  logic [BW-1:0] bcd_q;

  // Shift-and-add-3 conversion of the adder result, MSB first.
  always_comb begin
    bcd_d = '0;
    for (int i = int'(SW) - 1; i >= 0; i--) begin
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (bcd_d[4*d +: 4] >= 4'd5) begin
          bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
        end
      end
      bcd_d = {bcd_d[BW-2:0], sum_d[i]};
    end
  end

  // Output register for bcd; loads together with sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
    end else if (in_valid) begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;
`endif

  // Result register and valid flop; reset wins over an incoming valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_d;
      end
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_n_bit.sv
// Directed bench for adder_n_bit (N=10, DIGITS=4). bcd checks are active
// only when ADDER_BCD_OUT_EN is defined.
module tb_adder_n_bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [9:0]  a;
  logic [9:0]  b;
  logic        out_valid;
  logic [10:0] sum;
`ifdef ADDER_BCD_OUT_EN
  logic [15:0] bcd;
`endif

  int checks;
  int failures;

  adder_n_bit #(.N(10), .DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
`ifdef ADDER_BCD_OUT_EN
    .bcd       (bcd),
`endif
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 10'd5; b = 10'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (sum !== 11'd0) begin
        failures++; $display("FAIL reset_sum cyc=%0d got=%0d exp=0", i, sum);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, out_valid);
      end
`ifdef ADDER_BCD_OUT_EN
      checks++;
      if (bcd !== 16'h0000) begin
        failures++; $display("FAIL reset_bcd cyc=%0d got=%h exp=0000", i, bcd);
      end
`endif
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [9:0]  va [4] = '{10'd0, 10'd1, 10'd33, 10'd100};
    logic [9:0]  vb [4] = '{10'd0, 10'd99, 10'd66, 10'd47};
    logic [10:0] es [4] = '{11'd0, 11'd100, 11'd99, 11'd147};
    logic [15:0] eb [4] = '{16'h0000, 16'h0100, 16'h0099, 16'h0147};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i];
      tick();
      checks++;
      if (sum !== es[i]) begin
        failures++; $display("FAIL directed_sum idx=%0d got=%0d exp=%0d", i, sum, es[i]);
      end
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL directed_valid idx=%0d got=%b exp=1", i, out_valid);
      end
`ifdef ADDER_BCD_OUT_EN
      checks++;
      if (bcd !== eb[i]) begin
        failures++; $display("FAIL directed_bcd idx=%0d got=%h exp=%h", i, bcd, eb[i]);
      end
`else
      if (eb[i] == 16'hffff) $display("unreachable");
`endif
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL directed_drop got=%b exp=0", out_valid);
    end
    checks++;
    if (sum !== 11'd147) begin
      failures++; $display("FAIL directed_tail_hold got=%0d exp=147", sum);
    end
  endtask

  task automatic test_carry();
    logic [9:0]  va [2] = '{10'd1023, 10'd512};
    logic [9:0]  vb [2] = '{10'd1023, 10'd512};
    logic [10:0] es [2] = '{11'd2046, 11'd1024};
    logic [15:0] eb [2] = '{16'h2046, 16'h1024};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i];
      tick();
      checks++;
      if (sum !== es[i]) begin
        failures++; $display("FAIL carry_sum idx=%0d got=%0d exp=%0d", i, sum, es[i]);
      end
      checks++;
      if (sum[10] !== 1'b1) begin
        failures++; $display("FAIL carry_msb idx=%0d got=%b exp=1", i, sum[10]);
      end
`ifdef ADDER_BCD_OUT_EN
      checks++;
      if (bcd !== eb[i]) begin
        failures++; $display("FAIL carry_bcd idx=%0d got=%h exp=%h", i, bcd, eb[i]);
      end
`else
      if (eb[i] == 16'hffff) $display("unreachable");
`endif
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    in_valid = 1'b1; a = 10'd33; b = 10'd66;
    tick();
    checks++;
    if (sum !== 11'd99 || out_valid !== 1'b1) begin
      failures++; $display("FAIL hold_load got sum=%0d v=%b exp sum=99 v=1", sum, out_valid);
    end
    in_valid = 1'b0; a = 10'd7; b = 10'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sum !== 11'd99) begin
        failures++; $display("FAIL hold_sum cyc=%0d got=%0d exp=99", i, sum);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=0", i, out_valid);
      end
`ifdef ADDER_BCD_OUT_EN
      checks++;
      if (bcd !== 16'h0099) begin
        failures++; $display("FAIL hold_bcd cyc=%0d got=%h exp=0099", i, bcd);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; in_valid = 1'b1; a = 10'd100; b = 10'd47;
    tick();
    checks++;
    if (sum !== 11'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midreset got sum=%0d v=%b exp sum=0 v=0", sum, out_valid);
    end
    rst = 1'b0; a = 10'd1; b = 10'd1;
    tick();
    checks++;
    if (sum !== 11'd2 || out_valid !== 1'b1) begin
      failures++; $display("FAIL after_reset got sum=%0d v=%b exp sum=2 v=1", sum, out_valid);
    end
`ifdef ADDER_BCD_OUT_EN
    checks++;
    if (bcd !== 16'h0002) begin
      failures++; $display("FAIL after_reset_bcd got=%h exp=0002", bcd);
    end
`endif
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL after_reset_drop got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned ea;
    int unsigned eb;
    int unsigned es;
    for (int i = 0; i < 24; i++) begin
      ea = $urandom_range(1023, 0);
      eb = $urandom_range(1023, 0);
      es = ea + eb;
      in_valid = 1'b1; a = 10'(ea); b = 10'(eb);
      tick();
      checks++;
      if (sum !== 11'(es) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_sum idx=%0d a=%0d b=%0d got=%0d v=%b exp=%0d v=1", i, ea, eb, sum, out_valid, es);
      end
`ifdef ADDER_BCD_OUT_EN
      checks++;
      if (bcd !== to_bcd(es)) begin
        failures++; $display("FAIL b2b_bcd idx=%0d got=%h exp=%h", i, bcd, to_bcd(es));
      end
`endif
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_carry();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
